// File: rtl/rx_fifo_param.sv
// Parametrised single-clock show-ahead receive FIFO with occupancy and threshold flags.
// Define RX_FIFO_ERR_EN to build the sticky overflow/underflow flag registers.
module rx_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       w_enable,
  input  logic [DATA_WIDTH-1:0]      w_data,
  input  logic                       r_enable,
  output logic [DATA_WIDTH-1:0]      r_data,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_empty,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_empty = (count <= AE_C);
  assign almost_full  = (count >= AF_C);
  assign r_data       = empty ? '0 : mem[rd_ptr];

  // Simultaneous push+pop resolves naturally: pop is blocked when empty, push when full.
  assign push_ok = w_enable & ~full;
  assign pop_ok  = r_enable & ~empty;

  always_ff @(posedge clk) begin
    if (!rst && !flush && push_ok) begin
      mem[wr_ptr] <= w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef RX_FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_enable && full)  overflow  <= 1'b1;
      if (r_enable && empty) underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_rx_fifo_param.sv
// Self-checking bench for rx_fifo_param: vector table, directed corner sequences and
// randomized traffic, all compared against a queue-based reference model.
module tb_rx_fifo_param;

  logic       clk = 1'b0;
  logic       rst, flush, w_enable, r_enable;
  logic [7:0] w_data;
  logic [7:0] r_data;
  logic       empty, full, almost_empty, almost_full, overflow, underflow;
  logic [3:0] count;

  rx_fifo_param #(
    .DATA_WIDTH(8),
    .DEPTH(8),
    .AF_THRESH(6),
    .AE_THRESH(1)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .w_enable(w_enable), .w_data(w_data), .r_enable(r_enable),
    .r_data(r_data), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

`ifdef RX_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  bit         m_ov = 1'b0;
  bit         m_un = 1'b0;

  typedef struct {
    bit         rst;
    bit         flush;
    bit         we;
    logic [7:0] wd;
    bit         re;
    int         exp_count;
    logic [7:0] exp_rdata;
    bit         exp_af;
    bit         exp_full;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit f, input bit we, input logic [7:0] wd,
                            input bit re);
    bit was_full, was_empty;
    if (r || f) begin
      q.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      was_full  = (q.size() == 8);
      was_empty = (q.size() == 0);
      if (we && was_full)  m_ov = 1'b1;
      if (re && was_empty) m_un = 1'b1;
      if (re && !was_empty) void'(q.pop_front());
      if (we && !was_full)  q.push_back(wd);
    end
  endtask

  task automatic check_model();
    chk("count", int'(count), q.size());
    chk("empty", int'(empty), int'(q.size() == 0));
    chk("full", int'(full), int'(q.size() == 8));
    chk("almost_empty", int'(almost_empty), int'(q.size() <= 1));
    chk("almost_full", int'(almost_full), int'(q.size() >= 6));
    chk("r_data", int'(r_data), (q.size() != 0) ? int'(q[0]) : 0);
    chk("overflow", int'(overflow), ERR_EN ? int'(m_ov) : 0);
    chk("underflow", int'(underflow), ERR_EN ? int'(m_un) : 0);
  endtask

  task automatic step(input bit r, input bit f, input bit we, input logic [7:0] wd,
                      input bit re);
    rst = r; flush = f; w_enable = we; w_data = wd; r_enable = re;
    @(posedge clk);
    model_edge(r, f, we, wd, re);
    #1;
    check_model();
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; w_enable = 1'b0; w_data = '0; r_enable = 1'b0;

    // Test 1 as a vector table: reset, push A1..A8, pop eight.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 0, 8'h00, 1'b0, 1'b0};
    for (int i = 1; i <= 8; i++)
      tbl[i] = '{1'b0, 1'b0, 1'b1, 8'hA0 + 8'(i), 1'b0, i, 8'hA1, i >= 6, i == 8};
    for (int k = 1; k <= 8; k++)
      tbl[8 + k] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8 - k,
                     (k < 8) ? 8'hA1 + 8'(k) : 8'h00, (8 - k) >= 6, 1'b0};
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].rst, tbl[i].flush, tbl[i].we, tbl[i].wd, tbl[i].re);
      chk("tbl_count", int'(count), tbl[i].exp_count);
      chk("tbl_rdata", int'(r_data), int'(tbl[i].exp_rdata));
      chk("tbl_af", int'(almost_full), int'(tbl[i].exp_af));
      chk("tbl_full", int'(full), int'(tbl[i].exp_full));
    end

    // Test 2: overflow attempt while full; 0xFF must never surface.
    for (int i = 0; i < 8; i++) step(0, 0, 1, 8'h10 + 8'(i), 0);
    step(0, 0, 1, 8'hFF, 0);
    chk("ovf_count", int'(count), 8);
    chk("ovf_flag", int'(overflow), int'(ERR_EN));
    step(0, 0, 0, 8'h00, 0);
    chk("ovf_held", int'(overflow), int'(ERR_EN));
    for (int i = 0; i < 8; i++) begin
      chk("ovf_drain", int'(r_data), 16 + i);
      step(0, 0, 0, 8'h00, 1);
    end

    // Test 3: pops while empty.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, 1);
    chk("unf_count", int'(count), 0);
    chk("unf_flag", int'(underflow), int'(ERR_EN));

    // Test 4: streaming at occupancy 3 across two pointer wraps.
    step(0, 1, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h30 + 8'(i), 0);
    for (int i = 0; i < 20; i++) begin
      chk("stream_head", int'(r_data), 8'h30 + i);
      step(0, 0, 1, 8'h33 + 8'(i), 1);
    end
    chk("stream_count", int'(count), 3);

    // Test 5: push+pop while full, then while empty.
    step(0, 1, 0, 8'h00, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 8'h40 + 8'(i), 0);
    step(0, 0, 1, 8'h55, 1);
    chk("full_pp_count", int'(count), 7);
    chk("full_pp_head", int'(r_data), 8'h41);
    while (!empty && checks < 100000) step(0, 0, 0, 8'h00, 1);
    step(0, 0, 1, 8'h66, 1);
    chk("empty_pp_count", int'(count), 1);
    chk("empty_pp_data", int'(r_data), 8'h66);

    // Test 6: flush, then reset, at count 5 with sticky flags set.
    for (int pass = 0; pass < 2; pass++) begin
      step(0, 1, 0, 8'h00, 0);
      step(0, 0, 0, 8'h00, 1);
      for (int i = 0; i < 9; i++) step(0, 0, 1, 8'h70 + 8'(i), 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, 1);
      chk("pre_clear_count", int'(count), 5);
      chk("pre_clear_ovf", int'(overflow), int'(ERR_EN));
      step(pass == 1, pass == 0, 1, 8'hEE, 1);
      chk("clear_count", int'(count), 0);
      chk("clear_empty", int'(empty), 1);
      chk("clear_flags", int'({overflow, underflow}), 0);
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 79) == 0,
           $urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
